// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer
//   Byte-stream front end for spi_master. Host bytes are queued in a TX FIFO
//   and each one is issued as a single spi_master transaction (one-cycle
//   m_start pulse). Every received byte is collected into an RX FIFO.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   enable               launch permission; an in-flight transfer always completes
//   cpol, cpha, clk_div  SPI configuration, latched at each launch
//   tx_wdata/wvalid      host write into the TX FIFO
//   tx_wready            TX FIFO not full
//   rx_rdata/rvalid      RX FIFO head (first-word fall-through, 0 while empty)
//   rx_rready            host pop of the RX head
//   tx_level, rx_level   FIFO occupancies
//   err_timeout/err_clr  sticky "spi_master never went busy" flag and its clear
//   m_*                  connection to spi_master
module spi_xfer_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          cpol,
    input  logic          cpha,
    input  logic [1:0]    clk_div,
    input  logic [7:0]    tx_wdata,
    input  logic          tx_wvalid,
    output logic          tx_wready,
    output logic [7:0]    rx_rdata,
    output logic          rx_rvalid,
    input  logic          rx_rready,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic          err_timeout,
    input  logic          err_clr,
    output logic          m_start,
    output logic [7:0]    m_tx_data,
    output logic          m_cpol,
    output logic          m_cpha,
    output logic [1:0]    m_clk_div,
    input  logic [7:0]    m_rx_data,
    input  logic          m_rx_valid,
    input  logic          m_busy
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DATA,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    logic [2:0]    r_timer;
    logic          r_m_start;
    logic [7:0]    r_m_tx_data;
    logic          r_m_cpol;
    logic          r_m_cpha;
    logic [1:0]    r_m_clk_div;
    logic          r_err;

    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wptr;
    logic [AW-1:0] r_tx_rptr;
    logic [AW:0]   r_tx_cnt;

    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wptr;
    logic [AW-1:0] r_rx_rptr;
    logic [AW:0]   r_rx_cnt;

    logic          w_tx_push;
    logic          w_launch;
    logic          w_rx_push;
    logic          w_rx_pop;

    assign w_tx_push = tx_wvalid && (r_tx_cnt != FULL);
    // Launch pops the TX head; gating on RX room guarantees the RX FIFO
    // always has space for the byte this transaction will return.
    assign w_launch  = (r_state == S_IDLE) && enable && (r_tx_cnt != '0)
                       && (r_rx_cnt != FULL) && !m_busy;
    assign w_rx_push = ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DATA))
                       && m_rx_valid && (r_rx_cnt != FULL);
    assign w_rx_pop  = (r_rx_cnt != '0) && rx_rready;

    assign tx_wready   = (r_tx_cnt != FULL);
    assign tx_level    = r_tx_cnt;
    assign rx_level    = r_rx_cnt;
    assign rx_rvalid   = (r_rx_cnt != '0);
    assign rx_rdata    = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rptr] : '0;
    assign err_timeout = r_err;
    assign m_start     = r_m_start;
    assign m_tx_data   = r_m_tx_data;
    assign m_cpol      = r_m_cpol;
    assign m_cpha      = r_m_cpha;
    assign m_clk_div   = r_m_clk_div;

    // FIFO storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= tx_wdata;
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= m_rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_cnt  <= '0;
            r_rx_wptr <= '0;
            r_rx_rptr <= '0;
            r_rx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_launch)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_launch})
                2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
                2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
                default: r_tx_cnt <= r_tx_cnt;
            endcase

            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
                2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_m_start   <= 1'b0;
            r_m_tx_data <= '0;
            r_m_cpol    <= 1'b0;
            r_m_cpha    <= 1'b0;
            r_m_clk_div <= '0;
            r_err       <= 1'b0;
        end else begin
            r_m_start <= 1'b0;
            // The timeout branch below assigns later, so a coincident
            // timeout overrides this clear.
            if (err_clr) r_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_m_tx_data <= r_tx_mem[r_tx_rptr];
                        r_m_cpol    <= cpol;
                        r_m_cpha    <= cpha;
                        r_m_clk_div <= clk_div;
                        r_m_start   <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // A byte that arrives before busy is ever seen is still
                    // captured; the RX push itself happens in the FIFO block.
                    if (m_rx_valid) begin
                        r_state <= S_WAIT_IDLE;
                    end else if (m_busy) begin
                        r_state <= S_WAIT_DATA;
                    end else if (r_timer == 3'd7) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_DATA: begin
                    if (m_rx_valid) r_state <= S_WAIT_IDLE;
                end
                S_WAIT_IDLE: begin
                    if (!m_busy) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Testbench for spi_xfer_sequencer. A behavioural spi_master stand-in loops
// every transmitted byte back as the received byte after a random transfer
// length; a queue of accepted host bytes predicts the RX stream.
module tb_spi_xfer_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          cpol;
    logic          cpha;
    logic [1:0]    clk_div;
    logic [7:0]    tx_wdata;
    logic          tx_wvalid;
    logic          tx_wready;
    logic [7:0]    rx_rdata;
    logic          rx_rvalid;
    logic          rx_rready;
    logic [AW:0]   tx_level;
    logic [AW:0]   rx_level;
    logic          err_timeout;
    logic          err_clr;
    logic          m_start;
    logic [7:0]    m_tx_data;
    logic          m_cpol;
    logic          m_cpha;
    logic [1:0]    m_clk_div;
    logic [7:0]    m_rx_data;
    logic          m_rx_valid;
    logic          m_busy;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cpol(cpol), .cpha(cpha),
        .clk_div(clk_div), .tx_wdata(tx_wdata), .tx_wvalid(tx_wvalid),
        .tx_wready(tx_wready), .rx_rdata(rx_rdata), .rx_rvalid(rx_rvalid),
        .rx_rready(rx_rready), .tx_level(tx_level), .rx_level(rx_level),
        .err_timeout(err_timeout), .err_clr(err_clr), .m_start(m_start),
        .m_tx_data(m_tx_data), .m_cpol(m_cpol), .m_cpha(m_cpha),
        .m_clk_div(m_clk_div), .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid),
        .m_busy(m_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int n_rx     = 0;

    logic [7:0] exp_q[$];
    logic [3:0] mode_q[$];   // {clk_div, cpol, cpha} seen at each start

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // spi_master stand-in: busy one cycle after start, random length,
    // then returns the transmitted byte with a one-cycle rx_valid.
    logic       stub_en;
    logic       sb_busy;
    logic       sb_valid;
    logic [7:0] sb_data;
    logic [7:0] sb_rdata;
    int         sb_cnt;

    assign m_busy     = sb_busy;
    assign m_rx_valid = sb_valid;
    assign m_rx_data  = sb_rdata;

    always @(posedge clk) begin
        if (reset || !stub_en) begin
            sb_busy  <= 1'b0;
            sb_valid <= 1'b0;
            sb_cnt   <= 0;
        end else begin
            sb_valid <= 1'b0;
            if (sb_busy) begin
                if (sb_cnt == 0) begin
                    sb_busy  <= 1'b0;
                    sb_valid <= 1'b1;
                    sb_rdata <= sb_data;
                end else begin
                    sb_cnt <= sb_cnt - 1;
                end
            end else if (m_start) begin
                sb_busy <= 1'b1;
                sb_cnt  <= int'($urandom_range(6, 2));
                sb_data <= m_tx_data;
                mode_q.push_back({m_clk_div, m_cpol, m_cpha});
            end
        end
    end

    // Start-pulse monitor and RX collector, sampled on the falling edge.
    logic prev_start = 1'b0;
    logic prev_busy  = 1'b0;
    int   since_fall = 1000;

    always @(negedge clk) begin
        if (prev_busy && !m_busy) since_fall = 0;
        else if (since_fall < 1000) since_fall++;
        if (m_start && !prev_start) begin
            n_starts++;
            chk("start_gap_ge2", 32'(since_fall >= 2), 1);
        end
        if (m_start && prev_start) chk("start_width", 0, 1);
        prev_start = m_start;
        prev_busy  = m_busy;

        if (rx_rvalid && rx_rready && !reset) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                chk("rx_unexpected", {24'd0, rx_rdata}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", {24'd0, rx_rdata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        int unsigned w;
        w = 0;
        while (!tx_wready && w < 1000) begin
            tick();
            w++;
        end
        chk("wready_wait", {31'd0, tx_wready}, 1);
        tx_wdata  = b;
        tx_wvalid = 1'b1;
        exp_q.push_back(b);
        tick();
        tx_wvalid = 1'b0;
    endtask

    task automatic drain(input bit rand_rdy);
        int unsigned w;
        w = 0;
        while ((exp_q.size() != 0 || m_busy) && w < 3000) begin
            if (rand_rdy) rx_rready = 1'($urandom_range(0, 1));
            else          rx_rready = 1'b1;
            tick();
            w++;
        end
        rx_rready = 1'b1;
        repeat (4) tick();
        chk("drain_remaining", exp_q.size(), 0);
        chk("drain_tx_level", {28'd0, tx_level}, 0);
        chk("drain_rx_level", {28'd0, rx_level}, 0);
    endtask

    task automatic wait_busy();
        int unsigned w;
        w = 0;
        while (!m_busy && w < 200) begin
            tick();
            w++;
        end
        chk("busy_seen", {31'd0, m_busy}, 1);
    endtask

    task automatic wait_start();
        int unsigned w;
        w = 0;
        while (!m_start && w < 200) begin
            tick();
            w++;
        end
        chk("start_seen", {31'd0, m_start}, 1);
    endtask

    initial begin
        int s0;
        int r0;
        logic [7:0] b;
        logic [3:0] md;
        logic [7:0] burst [3];

        reset = 1'b1; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; clk_div = 2'b00;
        tx_wdata = '0; tx_wvalid = 1'b0; rx_rready = 1'b1; err_clr = 1'b0;
        stub_en = 1'b1;
        repeat (3) tick();

        // Reset values (checked while reset is still applied and after release).
        chk("rst_tx_wready", {31'd0, tx_wready}, 1);
        chk("rst_rx_rvalid", {31'd0, rx_rvalid}, 0);
        chk("rst_rx_rdata", {24'd0, rx_rdata}, 0);
        chk("rst_tx_level", {28'd0, tx_level}, 0);
        chk("rst_rx_level", {28'd0, rx_level}, 0);
        chk("rst_err", {31'd0, err_timeout}, 0);
        chk("rst_m_start", {31'd0, m_start}, 0);
        chk("rst_m_tx_data", {24'd0, m_tx_data}, 0);
        chk("rst_m_mode", {28'd0, m_clk_div, m_cpol, m_cpha}, 0);
        reset = 1'b0;
        tick();
        chk("rst_m_start_idle", {31'd0, m_start}, 0);

        // Launch latency and config latching.
        cpol = 1'b1; cpha = 1'b0; clk_div = 2'b10;
        write_byte(8'hC3);
        chk("lat_tx_level_N", {28'd0, tx_level}, 1);
        chk("lat_start_N", {31'd0, m_start}, 0);
        tick();
        chk("lat_start_N1", {31'd0, m_start}, 1);
        chk("lat_tx_data", {24'd0, m_tx_data}, 32'hC3);
        chk("lat_mode", {28'd0, m_clk_div, m_cpol, m_cpha}, {28'd0, 2'b10, 1'b1, 1'b0});
        chk("lat_tx_level_N1", {28'd0, tx_level}, 0);
        tick();
        chk("lat_start_N2", {31'd0, m_start}, 0);
        drain(1'b0);

        // Ordered burst in mode 0, clk_div 01.
        cpol = 1'b0; cpha = 1'b0; clk_div = 2'b01;
        mode_q.delete();
        s0 = n_starts;
        burst[0] = 8'hA5; burst[1] = 8'h5A; burst[2] = 8'hF0;
        for (int i = 0; i < 3; i++) write_byte(burst[i]);
        drain(1'b0);
        chk("burst_starts", n_starts - s0, 3);
        chk("burst_modes", mode_q.size(), 3);
        while (mode_q.size() != 0) begin
            md = mode_q.pop_front();
            chk("burst_mode", {28'd0, md}, {28'd0, 2'b01, 1'b0, 1'b0});
        end

        // RX backpressure: 12 bytes, only 8 transactions can complete.
        rx_rready = 1'b0;
        s0 = n_starts;
        r0 = n_rx;
        for (int i = 1; i <= 12; i++) write_byte(8'(i));
        repeat (300) tick();
        chk("bp_rx_level", {28'd0, rx_level}, 8);
        chk("bp_tx_level", {28'd0, tx_level}, 4);
        chk("bp_starts", n_starts - s0, 8);
        chk("bp_rx_head", {24'd0, rx_rdata}, 32'h01);
        drain(1'b0);
        chk("bp_rx_count", n_rx - r0, 12);

        // TX full with launches disabled: bytes 9 and 10 are dropped.
        enable = 1'b0;
        r0 = n_rx;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            tx_wdata  = b;
            tx_wvalid = 1'b1;
            if (i < DEPTH) exp_q.push_back(b);
            tick();
            tx_wvalid = 1'b0;
            chk("full_wready", {31'd0, tx_wready}, (i + 1 < DEPTH) ? 1 : 0);
            chk("full_level", {28'd0, tx_level}, (i + 1 < DEPTH) ? i + 1 : DEPTH);
        end
        repeat (20) tick();
        chk("full_no_launch", {28'd0, tx_level}, DEPTH);
        enable = 1'b1;
        drain(1'b0);
        chk("full_rx_count", n_rx - r0, DEPTH);

        // Mode change during the first of two transfers.
        cpol = 1'b0; cpha = 1'b0; clk_div = 2'b00;
        mode_q.delete();
        write_byte(8'h0F);
        write_byte(8'h33);
        wait_busy();
        cpol = 1'b1; cpha = 1'b1;
        tick();
        chk("mode_hold", {30'd0, m_cpol, m_cpha}, 0);
        drain(1'b0);
        chk("mode_count", mode_q.size(), 2);
        md = (mode_q.size() > 0) ? mode_q.pop_front() : 4'hF;
        chk("mode_first", {28'd0, md}, 0);
        md = (mode_q.size() > 0) ? mode_q.pop_front() : 4'hF;
        chk("mode_second", {28'd0, md}, 32'h3);

        // Randomized traffic with random host backpressure.
        clk_div = 2'($urandom); cpol = 1'($urandom); cpha = 1'($urandom);
        mode_q.delete();
        s0 = n_starts;
        for (int i = 0; i < 24; i++) begin
            rx_rready = 1'($urandom_range(0, 1));
            write_byte(8'($urandom));
        end
        drain(1'b1);
        chk("rand_starts", n_starts - s0, 24);
        while (mode_q.size() != 0) begin
            md = mode_q.pop_front();
            chk("rand_mode", {28'd0, md}, {28'd0, clk_div, cpol, cpha});
        end

        // Reset in the middle of a transfer with bytes queued.
        rx_rready = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_busy();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("mrst_tx_level", {28'd0, tx_level}, 0);
        chk("mrst_rx_level", {28'd0, rx_level}, 0);
        chk("mrst_m_start", {31'd0, m_start}, 0);
        chk("mrst_rx_rvalid", {31'd0, rx_rvalid}, 0);
        s0 = n_starts;
        repeat (10) tick();
        chk("mrst_no_restart", n_starts - s0, 0);
        chk("mrst_rx_rvalid_late", {31'd0, rx_rvalid}, 0);
        rx_rready = 1'b1;
        write_byte(8'h55);
        drain(1'b0);

        // Timeout with an unresponsive spi_master.
        stub_en = 1'b0;
        tick();
        tx_wdata = 8'h77; tx_wvalid = 1'b1;
        tick();
        tx_wvalid = 1'b0;
        wait_start();
        repeat (8) tick();
        chk("to_not_yet", {31'd0, err_timeout}, 0);
        tick();
        chk("to_set", {31'd0, err_timeout}, 1);
        chk("to_no_rx", {28'd0, rx_level}, 0);
        chk("to_tx_empty", {28'd0, tx_level}, 0);
        repeat (3) tick();
        chk("to_sticky", {31'd0, err_timeout}, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to_clr", {31'd0, err_timeout}, 0);

        // Second timeout (also proves the FSM returned to idle) with a
        // coincident clear: the set must win.
        tx_wdata = 8'h78; tx_wvalid = 1'b1;
        tick();
        tx_wvalid = 1'b0;
        wait_start();
        repeat (8) tick();
        chk("to2_not_yet", {31'd0, err_timeout}, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to2_set_wins", {31'd0, err_timeout}, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
